bitmanip_issue_ctrl: RTL

Issue controller that shares one `bitmanip_top` instance between two requesters. It round-robin arbitrates the requesters, decodes a compact 5-bit opcode plus 7-bit immediate into the datapath's 23-bit one-hot instruction vector, and registers the operands for one execute cycle. It captures the result and returns it on a backpressured response channel tagged with the requester ID.

---
 rtl/bitmanip_ctrl_pkg.sv | 48 ++++
 rtl/bitmanip_rr_arb.sv | 32 +++
 rtl/bitmanip_issue_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bitmanip_ctrl_pkg.sv
// Shared types for the bitmanip issue controller: opcode map, FSM states,
// the operation register layout and the opcode-to-one-hot decoder.
package bitmanip_ctrl_pkg;

   localparam logic [4:0] OP_CLMUL   = 5'd0;
   localparam logic [4:0] OP_CLMULH  = 5'd1;
   localparam logic [4:0] OP_XPERM_N = 5'd2;
   localparam logic [4:0] OP_XPERM_B = 5'd3;
   localparam logic [4:0] OP_ROR     = 5'd4;
   localparam logic [4:0] OP_ROL     = 5'd5;
   localparam logic [4:0] OP_RORI    = 5'd6;
   localparam logic [4:0] OP_ANDN    = 5'd7;
   localparam logic [4:0] OP_ORN     = 5'd8;
   localparam logic [4:0] OP_XNOR    = 5'd9;
   localparam logic [4:0] OP_PACK    = 5'd10;
   localparam logic [4:0] OP_PACKU   = 5'd11;
   localparam logic [4:0] OP_PACKH   = 5'd12;
   localparam logic [4:0] OP_GREVI   = 5'd13;
   localparam logic [4:0] OP_SHFL    = 5'd14;
   localparam logic [4:0] OP_UNSHFL  = 5'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [4:0]  op;
      logic [6:0]  imm;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        id;
   } op_reg_t;

   function automatic logic op_is_illegal(input logic [4:0] op);
      return op[4];
   endfunction

   // Opcode k selects one-hot bit 15-k; opcodes 16-31 decode to all-zero.
   function automatic logic [15:0] decode_op(input logic [4:0] op);
      logic [15:0] onehot;
      onehot = '0;
      if (!op[4]) onehot[4'd15 - op[3:0]] = 1'b1;
      return onehot;
   endfunction

endpackage

// File: rtl/bitmanip_rr_arb.sv
// Two-input round-robin arbiter; ptr is the requester that wins a tie and
// moves to the loser only when a grant is actually taken (advance).
module bitmanip_rr_arb #(
   parameter bit PRIO_RESET = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       ptr
);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= PRIO_RESET;
      else if (advance && (grant != 2'b00))
         ptr <= grant[0];
   end

endmodule

// File: rtl/bitmanip_issue_ctrl.sv
// Shares one bitmanip datapath between two requesters: arbitrate, decode, execute
// for one cycle, then return a tagged response. Option: BITMANIP_ISSUE_ILLEGAL_CHK_EN.
module bitmanip_issue_ctrl
   import bitmanip_ctrl_pkg::*;
#(
   parameter bit PRIO_RESET = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_op,
   input  logic [6:0]  req0_imm,
   input  logic [31:0] req0_rs1,
   input  logic [31:0] req0_rs2,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_op,
   input  logic [6:0]  req1_imm,
   input  logic [31:0] req1_rs1,
   input  logic [31:0] req1_rs2,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rd,
   output logic        resp_id,
   output logic        resp_err,
   output logic [22:0] bm_instruction,
   output logic [31:0] bm_rs1,
   output logic [31:0] bm_rs2,
   input  logic [31:0] bm_rd
);

   state_t     state, state_nxt;
   op_reg_t    op_q;
   logic       can_accept;
   logic       take;
   logic [1:0] grant;
   logic       prio;
   logic       win_id;
   logic       illegal;

   assign can_accept = !rst && ((state == IDLE) || ((state == RESP) && resp_ready));
   assign req0_ready = can_accept & grant[0];
   assign req1_ready = can_accept & grant[1];
   assign take       = req0_ready | req1_ready;
   assign win_id     = (req0_valid && req1_valid) ? prio : req1_valid;
   assign illegal    = op_is_illegal(op_q.op);
   assign resp_valid = (state == RESP);

   bitmanip_rr_arb #(
      .PRIO_RESET(PRIO_RESET)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .valid  ({req1_valid, req0_valid}),
      .advance(can_accept),
      .grant  (grant),
      .ptr    (prio)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = take ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the operation register is not reset; it is only observed in EXEC,
   // which is always entered through a load.
   always_ff @(posedge clk) begin
      if (take) begin
         op_q.op  <= win_id ? req1_op  : req0_op;
         op_q.imm <= win_id ? req1_imm : req0_imm;
         op_q.rs1 <= win_id ? req1_rs1 : req0_rs1;
         op_q.rs2 <= win_id ? req1_rs2 : req0_rs2;
         op_q.id  <= win_id;
      end
   end

   always_comb begin
      bm_instruction = '0;
      bm_rs1         = '0;
      bm_rs2         = '0;
      if (state == EXEC) begin
`ifdef BITMANIP_ISSUE_ILLEGAL_CHK_EN
         if (!illegal) begin
            bm_instruction = {op_q.imm, decode_op(op_q.op)};
            bm_rs1         = op_q.rs1;
            bm_rs2         = op_q.rs2;
         end
`else
         bm_instruction = {op_q.imm, decode_op(op_q.op)};
         bm_rs1         = op_q.rs1;
         bm_rs2         = op_q.rs2;
`endif
      end
   end

   // Result is captured at the end of EXEC and then held through RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_rd <= '0;
         resp_id <= 1'b0;
      end else if (state == EXEC) begin
         resp_rd <= illegal ? 32'h0 : bm_rd;
         resp_id <= op_q.id;
      end
   end

`ifdef BITMANIP_ISSUE_ILLEGAL_CHK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst)                 err_q <= 1'b0;
      else if (state == EXEC)  err_q <= illegal;
   end

   assign resp_err = err_q;
`else
   assign resp_err = 1'b0;
`endif

endmodule
